// File: rtl/vga_pkg.sv
// Shared VGA timing and framebuffer geometry, plus the scanout fetch state encoding.
package vga_pkg;

    localparam int unsigned HTOTAL   = 1600;
    localparam int unsigned VTOTAL   = 525;
    localparam int unsigned HACTIVE  = 1280;
    localparam int unsigned VACTIVE  = 480;
    localparam int unsigned LB_WIDTH = 160;
    localparam int unsigned FB_ROWS  = 120;
    localparam int unsigned FB_WORDS = LB_WIDTH * FB_ROWS;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain
    } fetch_state_e;

endpackage

// File: rtl/line_buffer.sv
// Two-bank scanline buffer: the fetch fills one bank while the display reads the other.
module line_buffer #(
    parameter int unsigned Width = 24,
    parameter int unsigned Depth = 160,
    localparam int unsigned IdxW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic             wr_bank_i,
    input  logic [IdxW-1:0]  wr_idx_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             rd_bank_i,
    input  logic [IdxW-1:0]  rd_idx_i,
    output logic [Width-1:0] rd_data_o
);

    logic [Width-1:0] mem_q [2][Depth];
    logic [Width-1:0] rd_data_q;

    // Contents are deliberately not reset; out-of-range reads occur only in blanking.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_bank_i][wr_idx_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_bank_i][rd_idx_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fb_scanout_arb.sv
// Framebuffer SRAM arbiter: row prefetch into a line buffer has absolute priority over host writes.
module fb_scanout_arb #(
    parameter int unsigned H_SCALE  = 4,
    parameter int unsigned LB_WIDTH = 160,
    parameter int unsigned FB_ROWS  = 120,
    parameter int unsigned HTOTAL   = 1600
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [14:0] host_addr,
    input  logic [23:0] host_data,
    output logic [14:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [23:0] mem_wdata,
    input  logic [23:0] mem_rdata,
    output logic [23:0] pixel_color,
    output logic        fetch_busy
);

    import vga_pkg::*;

    localparam logic [14:0] FbLimit   = 15'(FB_ROWS * LB_WIDTH);
    localparam logic [7:0]  XLast     = 8'(LB_WIDTH - 1);
    localparam logic [10:0] HLast     = 11'(HTOTAL - 1);
    localparam logic [9:0]  VFetchEnd = 10'(VACTIVE - 4);
    localparam logic [9:0]  VLast     = 10'(VTOTAL - 1);

    fetch_state_e state_q, state_d;
    logic [7:0]   x_q, x_d;
    logic [14:0]  base_q, base_d;
    logic         disp_bank_q, disp_bank_d;
    logic         row_ready_q, row_ready_d;
    logic         active_q, active_d;

    logic         fetch_start;
    logic [6:0]   fetch_row;
    logic [14:0]  row_base;
    logic         lb_we;
    logic [23:0]  lb_rdata;

    // Row r is shown on lines 4r..4r+3, so it is fetched on the last line of row r-1;
    // row 0 is fetched on the final (blank) line of the frame.
    assign fetch_start = (hcount == '0) &&
                         (((vcount[1:0] == 2'd3) && (vcount < VFetchEnd)) || (vcount == VLast));
    assign fetch_row   = (vcount == VLast) ? 7'd0 : 7'(vcount[9:2] + 8'd1);
    assign row_base    = ({8'd0, fetch_row} << 7) + ({8'd0, fetch_row} << 5);
    assign active_d    = (hcount < 11'(HACTIVE)) && (vcount < 10'(VACTIVE));

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        base_d      = base_q;
        disp_bank_d = disp_bank_q;
        row_ready_d = row_ready_q;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = host_addr;
        mem_wdata   = host_data;
        host_ready  = 1'b0;
        fetch_busy  = 1'b0;
        lb_we       = 1'b0;

        if ((hcount == HLast) && row_ready_q) begin
            disp_bank_d = ~disp_bank_q;
            row_ready_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                host_ready = reset_n && !fetch_start;
                if (fetch_start) begin
                    state_d = StFetch;
                    x_d     = '0;
                    base_d  = row_base;
                end else if (host_valid && host_ready && (host_addr < FbLimit)) begin
                    mem_we = 1'b1;
                end
            end
            StFetch: begin
                mem_re     = 1'b1;
                mem_addr   = base_q + 15'(x_q);
                fetch_busy = 1'b1;
                lb_we      = (x_q != '0);
                x_d        = x_q + 8'd1;
                if (x_q == XLast) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                fetch_busy  = 1'b1;
                lb_we       = 1'b1;
                row_ready_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            x_q         <= '0;
            base_q      <= '0;
            disp_bank_q <= 1'b0;
            row_ready_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            base_q      <= base_d;
            disp_bank_q <= disp_bank_d;
            row_ready_q <= row_ready_d;
            active_q    <= active_d;
        end
    end

    // Read data lands one cycle after the read, hence index x-1 into the back bank.
    line_buffer #(
        .Width (24),
        .Depth (LB_WIDTH)
    ) u_line_buffer (
        .clk_i     (clk),
        .wr_en_i   (lb_we),
        .wr_bank_i (~disp_bank_q),
        .wr_idx_i  (x_q - 8'd1),
        .wr_data_i (mem_rdata),
        .rd_bank_i (disp_bank_q),
        .rd_idx_i  (8'(hcount[10:1] >> $clog2(H_SCALE))),
        .rd_data_o (lb_rdata)
    );

    assign pixel_color = active_q ? lb_rdata : 24'h0;

endmodule
